// File: rtl/sha1_msg_pad_if.sv
// Byte-stream input, block output and state/complete signals between the
// SHA-1 message padder (slave) and its surroundings (master).
interface sha1_msg_pad_if;
  logic         start;
  logic         in_valid;
  logic [7:0]   in_data;
  logic         in_keep;
  logic         in_last;
  logic         in_ready;
  logic         blk_valid;
  logic [511:0] blk_data;
  logic         blk_last;
  logic         blk_ready;
  logic [1:0]   state;
  logic         complete;

  modport master (
    output start, in_valid, in_data, in_keep, in_last, blk_ready, complete,
    input  in_ready, blk_valid, blk_data, blk_last, state
  );

  modport slave (
    input  start, in_valid, in_data, in_keep, in_last, blk_ready, complete,
    output in_ready, blk_valid, blk_data, blk_last, state
  );
endinterface

// File: rtl/sha1_msg_pad.sv
// SHA-1 front end: packs a byte stream big-endian into 512-bit blocks, appends
// 0x80 / zero fill / 64-bit bit length, and hands blocks to the core.
module sha1_msg_pad #(
  parameter int LEN_W = 64
) (
  input  logic          clk,
  input  logic          rst,
  sha1_msg_pad_if.slave bus
);

  // Low two bits of each encoding are the state-bus code seen by the finish stage.
  typedef enum logic [3:0] {
    S_IDLE      = 4'b0000,
    S_ABSORB    = 4'b0001,
    S_PAD       = 4'b0101,
    S_TAIL      = 4'b1001,
    S_EMIT      = 4'b0010,
    S_EMIT_LAST = 4'b0110,
    S_FINISH    = 4'b0011
  } fsm_t;

  typedef enum logic [1:0] {
    PEND_NONE = 2'b00,
    PEND_LEN  = 2'b01,
    PEND_80   = 2'b10
  } pend_t;

  fsm_t             fsm;
  pend_t            pend;
  logic [511:0]     blk_q;
  logic [6:0]       idx;
  logic [LEN_W-1:0] bitcnt;
  logic             in_ready_q;
  logic             blk_valid_q;
  logic             blk_last_q;

  // Byte index i lives at byte lane 63-i, i.e. bits starting at (63-i)*8.
  function automatic logic [511:0] put_byte(input logic [511:0] b,
                                            input logic [6:0]   i,
                                            input logic [7:0]   d);
    logic [511:0] r;
    r = b;
    r[{~i[5:0], 3'b000} +: 8] = d;
    return r;
  endfunction

  function automatic logic [511:0] pad_block(input logic [511:0]     b,
                                             input logic [6:0]       i,
                                             input logic [LEN_W-1:0] len,
                                             input logic             with_len);
    logic [511:0] r;
    r = b;
    for (int k = 0; k < 64; k++) begin
      if (k == int'(i))
        r[(63 - k) * 8 +: 8] = 8'h80;
      else if (k > int'(i))
        r[(63 - k) * 8 +: 8] = 8'h00;
    end
    if (with_len)
      r[LEN_W-1:0] = len;
    return r;
  endfunction

  function automatic logic [511:0] tail_block(input logic             with_80,
                                              input logic [LEN_W-1:0] len);
    logic [511:0] r;
    r = '0;
    if (with_80)
      r[511:504] = 8'h80;
    r[LEN_W-1:0] = len;
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm         <= S_IDLE;
      pend        <= PEND_NONE;
      blk_q       <= '0;
      idx         <= '0;
      bitcnt      <= '0;
      in_ready_q  <= 1'b0;
      blk_valid_q <= 1'b0;
      blk_last_q  <= 1'b0;
    end else begin
      case (fsm)
        S_IDLE: begin
          if (bus.start) begin
            fsm        <= S_ABSORB;
            in_ready_q <= 1'b1;
            idx        <= '0;
            bitcnt     <= '0;
          end
        end

        S_ABSORB: begin
          if (bus.in_valid) begin
            if (bus.in_keep) begin
              blk_q  <= put_byte(blk_q, idx, bus.in_data);
              idx    <= idx + 7'd1;
              bitcnt <= bitcnt + LEN_W'(8);
            end
            if (bus.in_last) begin
              fsm        <= S_PAD;
              in_ready_q <= 1'b0;
            end else if (bus.in_keep && idx == 7'd63) begin
              fsm         <= S_EMIT;
              in_ready_q  <= 1'b0;
              blk_valid_q <= 1'b1;
              blk_last_q  <= 1'b0;
            end
          end
        end

        // Fewer than 8 free bytes after the 0x80 marker: length spills to an extra block.
        S_PAD: begin
          blk_valid_q <= 1'b1;
          if (idx <= 7'd55) begin
            blk_q      <= pad_block(blk_q, idx, bitcnt, 1'b1);
            blk_last_q <= 1'b1;
            fsm        <= S_EMIT_LAST;
          end else begin
            blk_q      <= pad_block(blk_q, idx, bitcnt, 1'b0);
            blk_last_q <= 1'b0;
            fsm        <= S_EMIT;
            pend       <= (idx == 7'd64) ? PEND_80 : PEND_LEN;
          end
        end

        S_EMIT: begin
          if (bus.blk_ready) begin
            blk_valid_q <= 1'b0;
            blk_q       <= '0;
            idx         <= '0;
            if (pend != PEND_NONE) begin
              fsm <= S_TAIL;
            end else begin
              fsm        <= S_ABSORB;
              in_ready_q <= 1'b1;
            end
          end
        end

        S_TAIL: begin
          blk_q       <= tail_block(pend == PEND_80, bitcnt);
          blk_valid_q <= 1'b1;
          blk_last_q  <= 1'b1;
          pend        <= PEND_NONE;
          fsm         <= S_EMIT_LAST;
        end

        S_EMIT_LAST: begin
          if (bus.blk_ready) begin
            blk_valid_q <= 1'b0;
            blk_last_q  <= 1'b0;
            blk_q       <= '0;
            idx         <= '0;
            fsm         <= S_FINISH;
          end
        end

        S_FINISH: begin
          if (bus.complete) begin
            fsm    <= S_IDLE;
            bitcnt <= '0;
          end
        end

        default: fsm <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.blk_valid = blk_valid_q;
  assign bus.blk_data  = blk_q;
  assign bus.blk_last  = blk_last_q;
  assign bus.state     = fsm[1:0];

endmodule

// File: tb/tb_sha1_msg_pad.sv
// Scoreboard bench for sha1_msg_pad: a reference SHA-1 padding model queues
// expected blocks per message; the monitor pops and compares on each handshake.
module tb_sha1_msg_pad;

  logic clk;
  logic rst;

  sha1_msg_pad_if bus ();

  sha1_msg_pad #(.LEN_W(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [511:0] d;
    logic         l;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference padding: message, 0x80, zeros to 56 mod 64, 64-bit big-endian bit length.
  task automatic push_expected(input int n, input int base);
    byte unsigned   m[$];
    longint unsigned bits;
    int             nb;
    exp_t           e;
    bits = longint'(n) * 8;
    for (int i = 0; i < n; i++) m.push_back(8'(base + i));
    m.push_back(8'h80);
    while (m.size() % 64 != 56) m.push_back(8'h00);
    for (int i = 7; i >= 0; i--) m.push_back(8'(bits >> (8 * i)));
    nb = m.size() / 64;
    for (int b = 0; b < nb; b++) begin
      e.d = '0;
      for (int j = 0; j < 64; j++) e.d = {e.d[503:0], m[b * 64 + j]};
      e.l = (b == nb - 1);
      sbq.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.blk_valid && bus.blk_ready) begin
      if (sbq.size() == 0) begin
        check("unexpected_block", 1, 0);
      end else begin
        e = sbq.pop_front();
        check("blk_data", bus.blk_data, e.d);
        check("blk_last", bus.blk_last, e.l);
        check("state_emit", bus.state, 2'b10);
      end
    end
  end

  task automatic push_beat(input logic [7:0] d, input logic k, input logic l);
    int t;
    t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_keep  = k;
    bus.in_last  = l;
    while (!bus.in_ready && t < 2000) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 2000) check("in_ready_timeout", 0, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_keep  = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic run_msg(input int n, input int base, input bit stall, input int gap_at);
    logic [511:0] held;
    int t;
    push_expected(n, base);
    pulse_start();
    check("start_to_absorb", bus.state, 2'b01);
    if (stall) bus.blk_ready = 1'b0;
    if (n == 0) begin
      push_beat(8'h00, 1'b0, 1'b1);
    end else begin
      for (int i = 0; i < n; i++) begin
        if (i == gap_at) push_beat(8'hEE, 1'b0, 1'b0);
        push_beat(8'(base + i), 1'b1, i == n - 1);
      end
    end
    if (stall) begin
      t = 0;
      while (!bus.blk_valid && t < 100) begin
        @(posedge clk); #1;
        t++;
      end
      check("stall_valid_seen", bus.blk_valid, 1);
      held = bus.blk_data;
      if (n == 3 && base == 'h61)
        check("abc_literal", held, {8'h61, 8'h62, 8'h63, 8'h80, 416'h0, 64'h18});
      for (int c = 0; c < 5; c++) begin
        @(posedge clk); #1;
        check("stall_data_stable", bus.blk_data, held);
        check("stall_valid_held", bus.blk_valid, 1);
        check("stall_in_ready", bus.in_ready, 0);
      end
      bus.blk_ready = 1'b1;
    end
    t = 0;
    while ((sbq.size() != 0 || bus.state != 2'b11) && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain_in_time", t < 3000, 1);
    check("finish_state", bus.state, 2'b11);
    check("finish_no_valid", bus.blk_valid, 0);
    bus.complete = 1'b1;
    @(posedge clk); #1;
    bus.complete = 1'b0;
    check("idle_after_complete", bus.state, 2'b00);
  endtask

  initial begin
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_keep   = 1'b0;
    bus.in_last   = 1'b0;
    bus.blk_ready = 1'b1;
    bus.complete  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", bus.state, 2'b00);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_blk_valid", bus.blk_valid, 0);
    check("rst_blk_last", bus.blk_last, 0);
    check("rst_blk_data", bus.blk_data, 0);
    rst = 1'b0;

    // Bytes offered while idle must not be taken.
    bus.in_valid = 1'b1;
    bus.in_keep  = 1'b1;
    bus.in_data  = 8'h5A;
    repeat (3) @(posedge clk);
    #1;
    check("idle_in_ready", bus.in_ready, 0);
    bus.in_valid = 1'b0;
    bus.in_keep  = 1'b0;

    run_msg(3, 'h61, 1'b1, -1);   // "abc" with a 5-cycle core stall
    run_msg(0, 0, 1'b0, -1);      // empty message
    run_msg(55, 0, 1'b0, -1);
    run_msg(56, 0, 1'b0, -1);
    run_msg(63, 'h10, 1'b0, -1);
    run_msg(64, 0, 1'b0, -1);
    run_msg(65, 'h20, 1'b0, 7);   // discarded keep=0 beat mid-message
    run_msg(128, 'h33, 1'b0, -1);

    // Stray start/complete during absorb, then reset mid-message.
    pulse_start();
    check("abort_absorb", bus.state, 2'b01);
    bus.complete = 1'b1;
    @(posedge clk); #1;
    bus.complete = 1'b0;
    check("complete_ignored", bus.state, 2'b01);
    pulse_start();
    check("start_ignored", bus.state, 2'b01);
    for (int i = 0; i < 10; i++) push_beat(8'(i), 1'b1, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_state", bus.state, 2'b00);
    check("midrst_blk_valid", bus.blk_valid, 0);
    check("midrst_in_ready", bus.in_ready, 0);
    check("midrst_blk_data", bus.blk_data, 0);
    run_msg(3, 'h61, 1'b0, -1);

    check("scoreboard_empty", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
